// File: rtl/biriscv_fetch_buffer.sv
// -----------------------------------------------------------------------------
// biriscv_fetch_buffer
//
// Instruction buffer between the fetch unit and the decoder. It queues 64-bit
// fetch packets (two 32-bit instructions each) and presents the oldest one or
// two pending instructions of the head packet to decode/issue. It supports
// partial consumption for dual issue and drops everything on a squash.
//
// Optional feature macro: FETCH_BUFFER_BYPASS_EN
//   When defined, an offered packet is presented combinationally on out* while
//   the buffer is empty. When undefined there is no fetch_* -> out* path.
//
// Parameters:
//   DEPTH           packet entries (power of two, >= 2)
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   fetch_valid_i   packet offered
//   fetch_instr_i   [31:0] instr at PC, [63:32] instr at PC+4
//   fetch_pc_i      packet PC; bit 2 set means entry at the odd word
//   fetch_fault_i   fault flag for the whole packet
//   fetch_accept_o  buffer can take a packet this cycle
//   squash_i        flush all contents
//   out0_*          oldest pending instruction (valid/instr/pc/fault)
//   out1_*          second-oldest instruction, same head packet only
//   pop_i           instructions consumed this cycle (0..2, clamped)
// -----------------------------------------------------------------------------
module biriscv_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  input  logic [63:0] fetch_instr_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_fault_i,
  output logic        fetch_accept_o,
  input  logic        squash_i,
  output logic        out0_valid_o,
  output logic [31:0] out0_instr_o,
  output logic [31:0] out0_pc_o,
  output logic        out0_fault_o,
  output logic        out1_valid_o,
  output logic [31:0] out1_instr_o,
  output logic [31:0] out1_pc_o,
  output logic        out1_fault_o,
  input  logic [1:0]  pop_i
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Packet storage (data only, no reset needed: gated by count/slot-valid)
  logic [63:0] r_instr    [DEPTH];
  logic [31:3] r_pc       [DEPTH];
  logic        r_fault    [DEPTH];
  logic [1:0]  r_slot_vld [DEPTH];

  // Control state
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_head_consumed;

  // Head view
  logic [63:0] w_head_instr;
  logic [31:3] w_head_pc;
  logic        w_head_fault;
  logic [1:0]  w_head_rem;
  logic        w_byp;

  logic [1:0]  w_rem_cnt;
  logic [1:0]  w_pop_clamp;
  logic        w_retire;
  logic        w_partial;
  logic        w_push;
  logic        w_wr_en;
  logic        w_rd_adv;
  logic        w_out0_slot;
  logic [1:0]  w_new_slot_vld;
  logic        w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^fetch_pc_i[1:0];

  // An odd-word entry PC means slot 0 precedes a branch target: drop it.
  assign w_new_slot_vld = fetch_pc_i[2] ? 2'b10 : 2'b11;

  assign fetch_accept_o = (r_count != FULL_CNT);

  always_comb begin
    w_head_instr = r_instr[r_rd_ptr];
    w_head_pc    = r_pc[r_rd_ptr];
    w_head_fault = r_fault[r_rd_ptr];
    // Slot 0 is masked once it has been consumed by a single pop.
    w_head_rem   = (r_count != '0) ?
                   (r_slot_vld[r_rd_ptr] & {1'b1, ~r_head_consumed}) : 2'b00;
    w_byp        = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
    if ((r_count == '0) && fetch_valid_i && !squash_i) begin
      w_byp        = 1'b1;
      w_head_instr = fetch_instr_i;
      w_head_pc    = fetch_pc_i[31:3];
      w_head_fault = fetch_fault_i;
      w_head_rem   = w_new_slot_vld;
    end
`endif
  end

  // Pop is clamped to what is actually presented; excess is ignored.
  assign w_rem_cnt   = {1'b0, w_head_rem[0]} + {1'b0, w_head_rem[1]};
  assign w_pop_clamp = (pop_i > w_rem_cnt) ? w_rem_cnt : pop_i;
  assign w_retire    = (w_rem_cnt != 2'd0) && (w_pop_clamp == w_rem_cnt);
  assign w_partial   = (w_pop_clamp == 2'd1) && (w_head_rem == 2'b11);

  // A bypassed packet that is fully consumed never needs to be stored; the
  // read pointer only advances for stored entries.
  assign w_push   = fetch_valid_i & fetch_accept_o & ~squash_i;
  assign w_wr_en  = w_push & ~(w_byp & w_retire);
  assign w_rd_adv = w_retire & ~w_byp & ~squash_i;

  // Output mapping: out0 is the first remaining slot, out1 only when both remain
  assign w_out0_slot  = ~w_head_rem[0];
  assign out0_valid_o = |w_head_rem;
  assign out1_valid_o = &w_head_rem;

  assign out0_instr_o = !out0_valid_o ? 32'd0 :
                        (w_out0_slot ? w_head_instr[63:32] : w_head_instr[31:0]);
  assign out0_pc_o    = out0_valid_o ? {w_head_pc, w_out0_slot, 2'b00} : 32'd0;
  assign out0_fault_o = out0_valid_o & w_head_fault;

  assign out1_instr_o = out1_valid_o ? w_head_instr[63:32] : 32'd0;
  assign out1_pc_o    = out1_valid_o ? {w_head_pc, 3'b100} : 32'd0;
  assign out1_fault_o = out1_valid_o & w_head_fault;

  // Control registers: pointers, occupancy and partial-consumption flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_head_consumed <= 1'b0;
    end else if (squash_i) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_head_consumed <= 1'b0;
    end else begin
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_adv)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_wr_en) - CNT_W'(w_rd_adv);
      if (w_retire)
        r_head_consumed <= 1'b0;
      else if (w_partial)
        r_head_consumed <= 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_instr[r_wr_ptr]    <= fetch_instr_i;
      r_pc[r_wr_ptr]       <= fetch_pc_i[31:3];
      r_fault[r_wr_ptr]    <= fetch_fault_i;
      r_slot_vld[r_wr_ptr] <= w_new_slot_vld;
    end
  end

endmodule

// File: tb/tb_biriscv_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_biriscv_fetch_buffer
//
// Self-checking bench for biriscv_fetch_buffer. A reference model keeps a
// queue of packets, each with a count of instructions still pending; the
// expected outputs are the first pending instructions of the oldest packet.
// -----------------------------------------------------------------------------
module tb_biriscv_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk_i;
  logic        rst_i;
  logic        fetch_valid_i;
  logic [63:0] fetch_instr_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_fault_i;
  logic        fetch_accept_o;
  logic        squash_i;
  logic        out0_valid_o;
  logic [31:0] out0_instr_o;
  logic [31:0] out0_pc_o;
  logic        out0_fault_o;
  logic        out1_valid_o;
  logic [31:0] out1_instr_o;
  logic [31:0] out1_pc_o;
  logic        out1_fault_o;
  logic [1:0]  pop_i;

  biriscv_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_instr_i  (fetch_instr_i),
    .fetch_pc_i     (fetch_pc_i),
    .fetch_fault_i  (fetch_fault_i),
    .fetch_accept_o (fetch_accept_o),
    .squash_i       (squash_i),
    .out0_valid_o   (out0_valid_o),
    .out0_instr_o   (out0_instr_o),
    .out0_pc_o      (out0_pc_o),
    .out0_fault_o   (out0_fault_o),
    .out1_valid_o   (out1_valid_o),
    .out1_instr_o   (out1_instr_o),
    .out1_pc_o      (out1_pc_o),
    .out1_fault_o   (out1_fault_o),
    .pop_i          (pop_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Model packet: rem = instructions of this packet still pending (1 or 2).
  typedef struct packed {
    logic [63:0] instr;
    logic [31:0] pc;
    logic        fault;
    logic [1:0]  rem;
  } pkt_t;

  pkt_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, clock, update.
  task automatic step(input logic v, input logic [63:0] ins, input logic [31:0] pc,
                      input logic flt, input logic sq, input logic [1:0] pop);
    pkt_t        view;
    pkt_t        np;
    logic        have;
    logic        push_ok;
    int          s;
    int          avail;
    int          n;
    logic [31:0] base;
    logic        e0v, e1v, e0f, e1f;
    logic [31:0] e0i, e0p, e1i, e1p;

    fetch_valid_i = v;
    fetch_instr_i = ins;
    fetch_pc_i    = pc;
    fetch_fault_i = flt;
    squash_i      = sq;
    pop_i         = pop;
    #2;

    np.instr = ins;
    np.pc    = {pc[31:2], 2'b00};
    np.fault = flt;
    np.rem   = pc[2] ? 2'd1 : 2'd2;

    view = '0;
    have = (q.size() > 0);
    if (have) view = q[0];
`ifdef FETCH_BUFFER_BYPASS_EN
    else if (v && !sq) begin
      have = 1'b1;
      view = np;
    end
`endif

    e0v = 0; e1v = 0; e0f = 0; e1f = 0;
    e0i = 0; e0p = 0; e1i = 0; e1p = 0;
    if (have) begin
      s    = 2 - int'(view.rem);
      base = {view.pc[31:3], 3'b000};
      e0v  = 1;
      e0i  = 32'(view.instr >> (32 * s));
      e0p  = base + 32'(4 * s);
      e0f  = view.fault;
      if (view.rem == 2'd2) begin
        e1v = 1;
        e1i = view.instr[63:32];
        e1p = base + 32'd4;
        e1f = view.fault;
      end
    end

    chk("accept",    fetch_accept_o, (q.size() != DEPTH));
    chk("out0_vld",  out0_valid_o,   e0v);
    chk("out0_ins",  out0_instr_o,   e0i);
    chk("out0_pc",   out0_pc_o,      e0p);
    chk("out0_flt",  out0_fault_o,   e0f);
    chk("out1_vld",  out1_valid_o,   e1v);
    chk("out1_ins",  out1_instr_o,   e1i);
    chk("out1_pc",   out1_pc_o,      e1p);
    chk("out1_flt",  out1_fault_o,   e1f);

    avail = have ? int'(view.rem) : 0;
    n     = (int'(pop) < avail) ? int'(pop) : avail;

    @(posedge clk_i);
    #1;

    if (sq) begin
      q.delete();
    end else begin
      push_ok = v && (q.size() < DEPTH);
      if (q.size() > 0) begin
        q[0].rem = q[0].rem - 2'(n);
        if (q[0].rem == 2'd0) void'(q.pop_front());
      end
`ifdef FETCH_BUFFER_BYPASS_EN
      else if (v) begin
        np.rem = np.rem - 2'(n);
        if (np.rem == 2'd0) push_ok = 1'b0;
      end
`endif
      if (push_ok) q.push_back(np);
    end
  endtask

  task automatic idle(input logic [1:0] pop);
    step(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, pop);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [63:0] rins;

    rst_i         = 1'b1;
    fetch_valid_i = 1'b0;
    fetch_instr_i = '0;
    fetch_pc_i    = '0;
    fetch_fault_i = 1'b0;
    squash_i      = 1'b0;
    pop_i         = 2'd0;
    #12;

    // Reset state
    chk("rst_accept",   fetch_accept_o, 1'b1);
    chk("rst_out0_vld", out0_valid_o,   1'b0);
    chk("rst_out1_vld", out1_valid_o,   1'b0);
    chk("rst_out0_ins", out0_instr_o,   32'd0);
    chk("rst_out0_pc",  out0_pc_o,      32'd0);
    rst_i = 1'b0;

    // Basic dual-instruction packet
    step(1'b1, {32'h00200113, 32'h00100093}, 32'h8000_0000, 1'b0, 1'b0, 2'd0);
    fetch_valid_i = 1'b0;
    #1;
    chk("t1_out0_ins", out0_instr_o, 32'h00100093);
    chk("t1_out0_pc",  out0_pc_o,    32'h80000000);
    chk("t1_out1_ins", out1_instr_o, 32'h00200113);
    chk("t1_out1_pc",  out1_pc_o,    32'h80000004);
    idle(2'd0);
    step(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 2'd0);

    // Odd-word entry: only the upper word is presented
    step(1'b1, {32'h11111111, 32'h22222222}, 32'h8000_0014, 1'b0, 1'b0, 2'd0);
    fetch_valid_i = 1'b0;
    #1;
    chk("t2_out0_ins", out0_instr_o, 32'h11111111);
    chk("t2_out0_pc",  out0_pc_o,    32'h80000014);
    chk("t2_out1_vld", out1_valid_o, 1'b0);
    chk("t2_out1_ins", out1_instr_o, 32'd0);
    step(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 2'd0);

    // Partial consumption and clamped pop
    step(1'b1, {32'hAAAA0001, 32'hAAAA0000}, 32'h0000_1000, 1'b0, 1'b0, 2'd0);
    step(1'b1, {32'hBBBB0001, 32'hBBBB0000}, 32'h0000_1008, 1'b0, 1'b0, 2'd0);
    idle(2'd1);
    idle(2'd2);
    idle(2'd0);
    idle(2'd2);
    idle(2'd0);

    // Full condition, retire while full, then steady push+pop with wrap
    for (int i = 0; i < 4; i++)
      step(1'b1, {32'hC000_0000 + 32'(2*i+1), 32'hC000_0000 + 32'(2*i)},
           32'h0000_2000 + 32'(8*i), 1'b0, 1'b0, 2'd0);
    step(1'b1, {32'hDDDD0001, 32'hDDDD0000}, 32'h0000_3000, 1'b0, 1'b0, 2'd2);
    for (int i = 0; i < 20; i++)
      step(1'b1, {32'hE000_0000 + 32'(2*i+1), 32'hE000_0000 + 32'(2*i)},
           32'h0000_4000 + 32'(8*i), 1'b0, 1'b0, 2'd2);
    step(1'b0, 64'd0, 32'd0, 1'b0, 1'b1, 2'd0);

    // Squash with concurrent push and pop
    for (int i = 0; i < 3; i++)
      step(1'b1, {32'hF000_0000 + 32'(2*i+1), 32'hF000_0000 + 32'(2*i)},
           32'h0000_5000 + 32'(8*i), 1'b0, 1'b0, 2'd0);
    step(1'b1, {32'h12345678, 32'h9ABCDEF0}, 32'h0000_6000, 1'b0, 1'b1, 2'd2);
    idle(2'd0);
    idle(2'd0);

    // Faulted packet
    step(1'b1, {32'h0000_0073, 32'h0000_0013}, 32'h9000_0000, 1'b1, 1'b0, 2'd0);
    fetch_valid_i = 1'b0;
    #1;
    chk("t6_out0_flt", out0_fault_o, 1'b1);
    chk("t6_out1_flt", out1_fault_o, 1'b1);
    chk("t6_out1_pc",  out1_pc_o,    32'h90000004);
    idle(2'd2);

    // Asynchronous reset mid-operation
    step(1'b1, {32'h55555555, 32'h44444444}, 32'h0000_7000, 1'b0, 1'b0, 2'd0);
    step(1'b1, {32'h77777777, 32'h66666666}, 32'h0000_7008, 1'b0, 1'b0, 2'd0);
    fetch_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("arst_out0_vld", out0_valid_o,   1'b0);
    chk("arst_out0_ins", out0_instr_o,   32'd0);
    chk("arst_accept",   fetch_accept_o, 1'b1);
    q.delete();
    #1;
    rst_i = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rpc  = $urandom;
      rins = {$urandom, $urandom};
      step(($urandom_range(0, 3) != 0), rins, rpc, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 24) == 0), 2'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
